// File: rtl/tt_sweep_checker_if.sv
// Bundle of sweep control, stimulus/response and result signals for tt_sweep_checker.
// The slave modport is the checker; the master modport is the bench/DUT-side environment.
interface tt_sweep_checker_if #(
    parameter int unsigned N  = 3,
    parameter int unsigned CH = 1
);
    localparam int unsigned L = 1 << N;

    logic              start;
    logic [CH*L-1:0]   exp;
    logic [N-1:0]      stim;
    logic [CH-1:0]     resp;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CH*L-1:0]   obs;
    logic [N+3:0]      err_cnt;
    logic [N-1:0]      first_err;

    modport master (
        output start, exp, resp,
        input  stim, busy, done, pass, obs, err_cnt, first_err
    );

    modport slave (
        input  start, exp, resp,
        output stim, busy, done, pass, obs, err_cnt, first_err
    );
endinterface

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper: drives 0..2^N-1, samples CH response bits after SETTLE
// extra cycles per index, and reports observed tables, mismatch count and first failing index.
module tt_sweep_checker #(
    parameter int unsigned N      = 3,
    parameter int unsigned CH     = 1,
    parameter int unsigned SETTLE = 1
) (
    input logic               clk,
    input logic               rst,
    tt_sweep_checker_if.slave bus
);
    localparam int unsigned    L         = 1 << N;
    localparam int unsigned    W         = CH * L;
    localparam logic [3:0]     HOLD_INIT = 4'(SETTLE);
    localparam logic [N-1:0]   LAST_IDX  = N'(L - 1);
    localparam logic [N-1:0]   STIM_ONE  = N'(1);
    localparam logic [N+3:0]   MISS_ONE  = (N + 4)'(1);

    typedef enum logic [1:0] {StIdle, StHold, StSample, StDone} state_e;

    state_e       r_state, w_state_next;
    logic [N-1:0] r_stim, w_stim_next;
    logic [3:0]   r_hold, w_hold_next;
    logic [W-1:0] r_exp, w_exp_next;
    logic [W-1:0] r_obs, w_obs_next;
    logic [N+3:0] r_err_cnt, w_err_cnt_next;
    logic [N-1:0] r_first_err, w_first_err_next;
    logic         r_pass, w_pass_next;
    logic [N+3:0] w_miss;
    logic [L-1:0] w_exp_ch;
    logic [L-1:0] w_obs_ch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_stim      <= '0;
            r_hold      <= '0;
            r_exp       <= '0;
            r_obs       <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_pass      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_stim      <= w_stim_next;
            r_hold      <= w_hold_next;
            r_exp       <= w_exp_next;
            r_obs       <= w_obs_next;
            r_err_cnt   <= w_err_cnt_next;
            r_first_err <= w_first_err_next;
            r_pass      <= w_pass_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_stim_next      = r_stim;
        w_hold_next      = r_hold;
        w_exp_next       = r_exp;
        w_obs_next       = r_obs;
        w_err_cnt_next   = r_err_cnt;
        w_first_err_next = r_first_err;
        w_pass_next      = r_pass;
        w_miss           = '0;
        w_exp_ch         = '0;
        w_obs_ch         = '0;

        // Case inequality so an X/Z response is flagged rather than silently matching.
        for (int c = 0; c < CH; c++) begin
            w_exp_ch = r_exp[c*L +: L];
            if (bus.resp[c] !== w_exp_ch[r_stim]) begin
                w_miss = w_miss + MISS_ONE;
            end
        end

        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_exp_next       = bus.exp;
                    w_obs_next       = '0;
                    w_err_cnt_next   = '0;
                    w_first_err_next = '0;
                    w_pass_next      = 1'b0;
                    w_stim_next      = '0;
                    w_hold_next      = HOLD_INIT;
                    w_state_next     = (HOLD_INIT == 4'd0) ? StSample : StHold;
                end
            end
            StHold: begin
                w_hold_next = r_hold - 4'd1;
                if (r_hold <= 4'd1) begin
                    w_state_next = StSample;
                end
            end
            StSample: begin
                for (int c = 0; c < CH; c++) begin
                    w_obs_ch                = w_obs_next[c*L +: L];
                    w_obs_ch[r_stim]        = bus.resp[c];
                    w_obs_next[c*L +: L]    = w_obs_ch;
                end
                w_err_cnt_next = r_err_cnt + w_miss;
                // err_cnt only grows, so a zero count means no earlier index failed.
                if ((w_miss != '0) && (r_err_cnt == '0)) begin
                    w_first_err_next = r_stim;
                end
                if (r_stim == LAST_IDX) begin
                    w_state_next = StDone;
                    w_stim_next  = '0;
                    w_pass_next  = (w_err_cnt_next == '0);
                end else begin
                    w_stim_next  = r_stim + STIM_ONE;
                    w_hold_next  = HOLD_INIT;
                    w_state_next = (HOLD_INIT == 4'd0) ? StSample : StHold;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign bus.stim      = r_stim;
    assign bus.busy      = (r_state == StHold) || (r_state == StSample);
    assign bus.done      = (r_state == StDone);
    assign bus.pass      = r_pass;
    assign bus.obs       = r_obs;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.first_err = r_first_err;
endmodule
